mux_sel_rr: RTL and testbench
=============================

MUX_SEL_RR -- requirements
Module: mux_sel_rr

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving the number of cycles each granted channel is held (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: scan enable; low forces the idle state.
REQ-005 The block SHALL have port req, input, [4:1]: per-channel request; req[n] corresponds to mux data input a[n].
REQ-006 The block SHALL have port c, output, [2:1]: registered select for the downstream 4:1 mux; 2'b00 selects a[1], 2'b01 a[2], 2'b10 a[3], 2'b11 a[4].
REQ-007 The block SHALL have port sel_valid, output, 1 bit: high while c addresses a granted channel.
REQ-008 The block SHALL have port sel_done, output, 1 bit: one-cycle pulse in the final dwell cycle of a grant.
REQ-009 The block SHALL have port idle, output, 1 bit: high when in the IDLE state.

Function
REQ-010 The block SHALL implement a two-state FSM, IDLE and HOLD, plus an 8-bit down-counter cnt and a 2-bit last-grant pointer ptr.
REQ-011 In IDLE with en=1 and req!=0, the block SHALL grant on the next edge: enter HOLD, set c to the granted channel, set sel_valid=1, load cnt=DWELL-1.
REQ-012 Grant selection SHALL be round-robin: search circularly starting at ptr+1 (mod 4) and take the first channel with req set; ptr SHALL be updated to the granted channel.
REQ-013 In IDLE with en=0 or req=0, the block SHALL remain in IDLE with sel_valid=0, and c SHALL hold its previous value.
REQ-014 In HOLD with en=1 and cnt!=0, cnt SHALL decrement by 1 per cycle, and c SHALL stay constant.
REQ-015 sel_done SHALL be high exactly when the state is HOLD and cnt==0, and low otherwise.
REQ-016 In HOLD with cnt==0 and en=1 and req!=0, the block SHALL regrant on the next edge with no idle gap, per REQ-012, reloading cnt=DWELL-1.
REQ-017 In HOLD with cnt==0 and (en=0 or req=0), the block SHALL return to IDLE on the next edge with sel_valid=0.
REQ-018 en falling during HOLD SHALL abort the grant: IDLE on the next edge, sel_valid=0, no sel_done pulse, ptr retained.
REQ-019 req SHALL be sampled only at grant decisions; dropping the granted channel's req mid-dwell SHALL NOT shorten the dwell.
REQ-020 With a single active requester, the block SHALL regrant that same channel back-to-back.
REQ-021 With DWELL=1, c SHALL be able to change every cycle, and sel_done SHALL equal sel_valid.
REQ-022 idle SHALL equal (state==IDLE), and sel_valid SHALL equal (state==HOLD).
REQ-023 All outputs SHALL be glitch-free registered or decoded-from-register signals, with no combinational path from req or en to any output.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL set state=IDLE, c=2'b00, sel_valid=0, sel_done=0, idle=1, cnt=0, ptr=2'b11, so that the first search starts at req[1].
REQ-025 Reset SHALL take priority over all other inputs, including mid-HOLD, with no partial-dwell completion.

Verification
REQ-026 The bench SHALL cover: DWELL=4, en=1, req=4'b1111 from reset -> c sequence 00,01,10,11,00, each held 4 cycles; sel_done pulses every 4th cycle; sel_valid continuously high.
REQ-027 The bench SHALL cover: req=4'b0100 only -> c=2'b10, regranted back-to-back, sel_valid never drops.
REQ-028 The bench SHALL cover: req=4'b1010 with ptr=2'b01 -> next grant c=2'b11, then c=2'b01.
REQ-029 The bench SHALL cover: en deasserted in dwell cycle 2 -> next cycle idle=1, sel_valid=0, no sel_done; c unchanged.
REQ-030 The bench SHALL cover: rst asserted mid-HOLD -> next cycle c=2'b00, sel_valid=0, idle=1; after release with req=4'b1000, grant c=2'b11.
REQ-031 The bench SHALL cover: DWELL=1, req=4'b0011 -> c alternates 00,01 every cycle; sel_done=1 throughout.

Source files
------------

// File: rtl/mux_sel_rr.sv
// Round-robin select generator for a downstream 4:1 mux.
// Each granted channel is held for DWELL cycles. When the final dwell cycle
// ends, the next requester is granted with no idle gap. The ptr register
// remembers the last grant, so the circular search starts just after it.
module mux_sel_rr #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:1] req,
    output logic [2:1] c,
    output logic       sel_valid,
    output logic       sel_done,
    output logic       idle
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [2:1] c_nxt;
    logic [3:0] req_v;
    logic [2:0] pick;

    // Circular search starting one past the last grant. The result is
    // {found, channel}, and found is low only when no request is set.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Re-base req so channel index 0..3 addresses a[1]..a[4].
    assign req_v = req;
    assign pick  = rr_pick(ptr, req_v);

    // Next-state logic. req is only consulted at grant decisions, so a
    // request that drops mid-dwell does not shorten the grant.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        c_nxt     = c;
        case (state)
            IDLE: begin
                if (en && pick[2]) begin
                    state_nxt = HOLD;
                    c_nxt     = pick[1:0];
                    ptr_nxt   = pick[1:0];
                    cnt_nxt   = CNT_LOAD;
                end
            end
            HOLD: begin
                if (!en) begin
                    // Abort: drop the grant at once. ptr keeps the last grant.
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else if (pick[2]) begin
                    c_nxt   = pick[1:0];
                    ptr_nxt = pick[1:0];
                    cnt_nxt = CNT_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter, pointer and select registers. ptr resets to 3 so the
    // first search begins at a[1].
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            ptr   <= 2'b11;
            c     <= 2'b00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            c     <= c_nxt;
        end
    end

    // Status outputs are decoded only from registers, so no path from req or en.
    assign sel_valid = (state == HOLD);
    assign idle      = (state == IDLE);
    assign sel_done  = (state == HOLD) && (cnt == 8'd0);

endmodule

// File: tb/tb_mux_sel_rr.sv
// Bench for mux_sel_rr. It drives two instances (DWELL=4 and DWELL=1) from the
// same inputs. A reference model tracks, for each instance, whether a channel
// is held, the remaining dwell cycles, and the last granted channel.
module tb_mux_sel_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:1] req;
    logic [2:1] c0, c1;
    logic       v0, v1, d0, d1, i0, i1;

    int checks   = 0;
    int failures = 0;

    int dw[2] = '{4, 1};
    bit m_busy[2];
    int m_c[2];
    int m_ptr[2];
    int m_left[2];

    always #5 clk = ~clk;

    mux_sel_rr #(.DWELL(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .c(c0), .sel_valid(v0), .sel_done(d0), .idle(i0)
    );

    mux_sel_rr #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .c(c1), .sel_valid(v1), .sel_done(d1), .idle(i1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge of the model using the inputs present at that edge.
    task automatic model_step(input int i);
        int  ch;
        bit  found;
        if (rst) begin
            m_busy[i] = 0; m_c[i] = 0; m_ptr[i] = 3; m_left[i] = 0;
            return;
        end
        if (m_busy[i] && !en) begin
            m_busy[i] = 0;
            return;
        end
        if (m_busy[i] && m_left[i] > 1) begin
            m_left[i]--;
            return;
        end
        if (!en) return;
        found = 0;
        for (int k = 1; k <= 4; k++) begin
            ch = (m_ptr[i] + k) % 4;
            if (!found && req[ch + 1]) begin
                found = 1; m_c[i] = ch; m_ptr[i] = ch;
            end
        end
        m_busy[i] = found;
        if (found) m_left[i] = dw[i];
    endtask

    task automatic tick(input logic r_, input logic e_, input logic [4:1] q_);
        rst = r_; en = e_; req = q_;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("c_d4",     32'(c0), 32'(m_c[0]));
        chk("valid_d4", 32'(v0), 32'(m_busy[0]));
        chk("done_d4",  32'(d0), 32'(m_busy[0] && m_left[0] == 1));
        chk("idle_d4",  32'(i0), 32'(!m_busy[0]));
        chk("c_d1",     32'(c1), 32'(m_c[1]));
        chk("valid_d1", 32'(v1), 32'(m_busy[1]));
        chk("done_d1",  32'(d1), 32'(m_busy[1] && m_left[1] == 1));
        chk("idle_d1",  32'(i1), 32'(!m_busy[1]));
    endtask

    initial begin
        // Reset state
        tick(1'b1, 1'b0, 4'b0000);
        tick(1'b1, 1'b0, 4'b0000);
        chk("rst_idle", 32'(i0), 32'd1);
        chk("rst_c",    32'(c0), 32'd0);
        chk("rst_done", 32'(d0), 32'd0);

        // All requesting: 00,01,10,11,00 each held 4 cycles
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b1, 4'b1111);
            chk("rr4_c",     32'(c0), 32'((k / 4) % 4));
            chk("rr4_done",  32'(d0), 32'((k % 4) == 3));
            chk("rr4_valid", 32'(v0), 32'd1);
        end

        // Single requester a[3]: back-to-back regrant
        tick(1'b1, 1'b0, 4'b0000);
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 1'b1, 4'b0100);
            chk("single_c",     32'(c0), 32'd2);
            chk("single_valid", 32'(v0), 32'd1);
        end

        // ptr=01, then req=1010 -> grant 11 then 01
        tick(1'b1, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 4'b0010);
        chk("ptr01_c", 32'(c0), 32'd1);
        tick(1'b0, 1'b1, 4'b1010);
        chk("rr1010_first", 32'(c0), 32'd3);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 4'b1010);
        chk("rr1010_second", 32'(c0), 32'd1);

        // en dropped in dwell cycle 2 aborts the grant
        tick(1'b1, 1'b0, 4'b0000);
        tick(1'b0, 1'b1, 4'b0100);
        tick(1'b0, 1'b1, 4'b0100);
        tick(1'b0, 1'b0, 4'b0100);
        chk("abort_idle",  32'(i0), 32'd1);
        chk("abort_valid", 32'(v0), 32'd0);
        chk("abort_done",  32'(d0), 32'd0);
        chk("abort_c",     32'(c0), 32'd2);

        // Reset mid-HOLD, then only a[4] requesting
        tick(1'b0, 1'b1, 4'b0010);
        tick(1'b0, 1'b1, 4'b0010);
        tick(1'b1, 1'b1, 4'b0010);
        chk("midrst_c",     32'(c0), 32'd0);
        chk("midrst_valid", 32'(v0), 32'd0);
        chk("midrst_idle",  32'(i0), 32'd1);
        tick(1'b0, 1'b1, 4'b1000);
        chk("postrst_c", 32'(c0), 32'd3);

        // DWELL=1 with req=0011: c alternates every cycle, sel_done held high
        tick(1'b1, 1'b0, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b1, 4'b0011);
            chk("d1_alt_c",    32'(c1), 32'(k % 2));
            chk("d1_alt_done", 32'(d1), 32'd1);
        end

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            tick(1'(($urandom % 40) == 0), 1'(($urandom % 8) != 0), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
